// File: rtl/mux8_scan_pkg.sv
// Shared types and constants for the mux8 truth-table sweep controller.
package mux8_scan_pkg;

  localparam int IDX_W = 3;
  localparam int TBL_W = 8;
  localparam int CNT_W = 4;

  localparam logic [TBL_W-1:0] MUX8_GOLDEN = 8'h39;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Four bits so that "all eight wrong" is representable.
  function automatic logic [3:0] popcount8(input logic [TBL_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < TBL_W; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/mux8_scan_if.sv
// Bundle between the sweep controller and its host / function block.
interface mux8_scan_if;
  import mux8_scan_pkg::*;

  logic             start;
  logic             y;
  logic             a, b, c;
  logic             busy;
  logic             done;
  logic [TBL_W-1:0] table_out;
  logic             pass;
  logic [3:0]       err_count;

  modport slave (
    input  start, y,
    output a, b, c, busy, done, table_out, pass, err_count
  );

  modport master (
    output start, y,
    input  a, b, c, busy, done, table_out, pass, err_count
  );
endinterface

// File: rtl/mux8_scan_ctrl_settle_timer.sv
// Per-index settle counter; hit marks the last cycle of an index window.
module settle_timer
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CNT_W'(SETTLE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = hit_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Sweeps {a,b,c} through 0..7, captures y per index and grades the table
// against EXPECTED. All outputs come straight from registers.
module mux8_scan_ctrl
  import mux8_scan_pkg::*;
#(
  parameter int               SETTLE   = 1,
  parameter logic [TBL_W-1:0] EXPECTED = MUX8_GOLDEN
) (
  input  logic        clk,
  input  logic        reset,
  mux8_scan_if.slave  bus
);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TBL_W-1:0] tbl_q, tbl_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hit;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != SCAN),
    .en_i    (state_q == SCAN),
    .hit_o   (hit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = '0;
          tbl_d   = '0;
          pass_d  = 1'b0;
          err_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit) begin
          tbl_d[idx_q] = bus.y;
          if (idx_q == IDX_W'(TBL_W - 1)) begin
            // idx returns to 0 so {a,b,c} reads 000 outside a sweep.
            state_d = DONE;
            idx_d   = '0;
            pass_d  = (tbl_d == EXPECTED);
            err_d   = popcount8(tbl_d ^ EXPECTED);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {bus.a, bus.b, bus.c} = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = tbl_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

endmodule

// File: doc/mux8_scan_ctrl.md
# mux8_scan_ctrl

Sequential sweep controller placed directly in front of the 3-input combinational function block `mux8_impl`, which computes y = (~b & a) | (~b & ~c) | (~a & b & c). On a start request it drives all eight {a,b,c} combinations in ascending order and waits a programmable settle time on each. It then captures y into an 8-bit truth-table register and compares that table against an expected constant. This gives the lab board a self-test of the function block without an external pattern source.

## Interface
- `SETTLE`, default 1: cycles each input combination is held before y is sampled; legal range 1..15.
- `EXPECTED`, default 8'h39: golden truth table, where bit i = y for {a,b,c} = i.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; all state and outputs cleared on the next clk edge.
- `start`  in  1  sweep request, sampled on clk; honoured only in IDLE or DONE.
- `a`, `b`, `c`  out  1 each  drive to `mux8_impl`; {a,b,c} = current index (a is MSB).
- `y`  in  1  function output from `mux8_impl`.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_out`  out  8  captured truth table; bit i = y sampled at index i.
- `pass`  out  1  (table_out == EXPECTED); valid from `done` until the next accepted `start`.
- `err_count`  out  4  popcount(table_out ^ EXPECTED), 0..8; same validity as `pass`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `busy`=0 and {a,b,c}=000.
  - `start`=1 → SCAN; clear the index, settle counter and `table_out`; clear `pass` and `err_count`.
- SCAN:
  - `busy`=1 and {a,b,c}=index.
  - The settle counter increments each cycle.
  - When counter == SETTLE-1, on that edge: `table_out[index]` <= y and the counter clears.
    - If index == 7 → DONE; also register `pass` and `err_count`, computed with the new bit included.
    - Otherwise index <= index+1.
- DONE:
  - `done`=1 for exactly this one cycle; `busy`=0.
  - `start`=1 → SCAN (restart, same clearing as from IDLE); otherwise → IDLE.
- `start` while in SCAN is ignored and does not queue.
- `table_out`, `pass` and `err_count` hold their values in IDLE until the next accepted `start`.
- Reset values:
  - state IDLE.
  - a=b=c=0, `busy`=0, `done`=0.
  - `table_out`=8'h00, `pass`=0, `err_count`=0.
- Reset asserted mid-sweep aborts the sweep: no `done`, partial table discarded (cleared to 0).
- Index is 3 bits and never wraps within a sweep; the terminal test is index == 7.
- `err_count` is 4 bits so that the value 8 (every bit wrong) is representable.

## Timing
- All outputs are registered; nothing is combinational from `y` or `start` to any output.
- `start` sampled high at edge k:
  - from edge k, `busy`=1 and {a,b,c}=000;
  - index i is driven during cycles k+i·SETTLE .. k+(i+1)·SETTLE-1.
- Latency from the accepting edge to `done` high: 8·SETTLE cycles.
  - SETTLE=1: `done` is high in the cycle after edge k+8.
- y is sampled at the last edge of each index window. `mux8_impl` must therefore settle within SETTLE clock periods.
- Back-to-back sweeps: `start` held high through DONE restarts the sweep with no IDLE cycle. Sweep period is 8·SETTLE+1 cycles.

## Structure
- Package `mux8_scan_pkg` holds:
  - state enum `scan_state_t` {IDLE, SCAN, DONE};
  - localparams IDX_W=3, TBL_W=8, CNT_W=4;
  - `MUX8_GOLDEN` = 8'h39.
- One sub-module, `settle_timer`: a CNT_W-bit counter with a `clear` input and a `hit` output that is high when count == SETTLE-1.
- The popcount for `err_count` stays inline as a function in the package.

## Test plan
- Reset, then `start` pulse with SETTLE=1 and a real `mux8_impl` connected:
  - {a,b,c} steps 0..7 on consecutive cycles;
  - `done` pulses at cycle 9 after the accepting edge;
  - `table_out`=8'h39, `pass`=1, `err_count`=0.
- Replace y with a model that inverts it at index 5:
  - `table_out`=8'h19, `pass`=0, `err_count`=1.
- Tie y=0:
  - `table_out`=8'h00, `err_count`=4, `pass`=0.
- SETTLE=3, with y driven from `mux8_impl` through a 2-cycle delay model:
  - each index held 3 cycles;
  - `done` appears 24 cycles after start;
  - `table_out`=8'h39.
- Pulse `start` again during SCAN at index 3: ignored, and the sweep completes normally with a single `done`.
- Assert `reset` at index 4: the next cycle shows `busy`=0, {a,b,c}=000, `table_out`=0 and no `done`. A fresh `start` then yields 8'h39.
